// File: rtl/bdd_vector_loader.sv
// bdd_vector_loader: assembles a wide evaluator input vector from a narrow
// beat stream, holds it for a fixed multicycle evaluation window, then
// captures the evaluator result bits and streams them back out in beats.
module bdd_vector_loader #(
  parameter int IN_W     = 1894,
  parameter int OUT_W    = 96,
  parameter int BEAT_W   = 32,
  parameter int EVAL_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [IN_W-1:0]   vec,
  input  logic [OUT_W-1:0]  res,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_frame
);

  localparam int NB_IN  = (IN_W + BEAT_W - 1) / BEAT_W;
  localparam int NB_OUT = (OUT_W + BEAT_W - 1) / BEAT_W;
  localparam int CNT_W  = $clog2(NB_IN + 1);
  localparam int OCNT_W = $clog2(NB_OUT + 1);
  localparam int RES_PW = NB_OUT * BEAT_W;

  localparam logic [CNT_W-1:0]  LAST_IN   = CNT_W'(NB_IN - 1);
  localparam logic [OCNT_W-1:0] LAST_OUT  = OCNT_W'(NB_OUT - 1);
  localparam logic [3:0]        EVAL_LAST = 4'(EVAL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_EVAL,
    S_SEND
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    beat_cnt_reg;
  logic [3:0]          eval_cnt_reg;
  logic [OCNT_W-1:0]   out_cnt_reg;
  logic [OCNT_W-1:0]   out_cnt_inc;
  logic [RES_PW-1:0]   res_sh_reg;
  logic [RES_PW-1:0]   res_shifted;
  logic                s_ready_reg;
  logic                m_valid_reg;
  logic                m_last_reg;
  logic [BEAT_W-1:0]   m_data_reg;
  logic                err_frame_reg;

  logic                accept;
  logic                wr_en;
  logic                set_err;
  logic                capture;
  logic                is_final;

  assign s_ready   = s_ready_reg;
  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign m_data    = m_data_reg;
  assign err_frame = err_frame_reg;
  assign busy      = (state_reg != S_IDLE);

  assign accept      = s_valid && s_ready_reg;
  assign is_final    = (beat_cnt_reg == LAST_IN);
  assign res_shifted = res_sh_reg >> BEAT_W;
  assign out_cnt_inc = out_cnt_reg + OCNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    set_err    = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      // IDLE and LOAD share the beat rules; beat_cnt_reg is 0 in IDLE
      S_IDLE, S_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_last && is_final) begin
            state_next = S_EVAL;
          end else if (s_last) begin
            set_err    = 1'b1;
            state_next = S_IDLE;   // frame already terminated, nothing to drain
          end else if (is_final) begin
            set_err    = 1'b1;
            state_next = S_DRAIN;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_last) state_next = S_IDLE;
      end
      S_EVAL: begin
        if (eval_cnt_reg == EVAL_LAST) begin
          capture    = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (m_valid_reg && m_ready && m_last_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Input ready follows the next state so it is low during EVAL/SEND and out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ready_reg <= 1'b0;
    else        s_ready_reg <= (state_next == S_IDLE) || (state_next == S_LOAD) ||
                               (state_next == S_DRAIN);
  end

  // Beat write pointer; restarts at 0 whenever the frame leaves LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     beat_cnt_reg <= '0;
    else if (wr_en) beat_cnt_reg <= (state_next == S_LOAD) ? beat_cnt_reg + CNT_W'(1) : '0;
  end

  // Evaluation window counter, only runs while staying in EVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           eval_cnt_reg <= '0;
    else if (state_reg == S_EVAL && state_next == S_EVAL) eval_cnt_reg <= eval_cnt_reg + 4'd1;
    else                                                  eval_cnt_reg <= '0;
  end

  // Vector slots; the last slot is narrower and drops the beat's pad bits
  for (genvar gi = 0; gi < NB_IN; gi++) begin : g_slot
    localparam int LO = gi * BEAT_W;
    localparam int SW = (IN_W - LO < BEAT_W) ? (IN_W - LO) : BEAT_W;
    localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
    logic [SW-1:0] slot_reg;

    // Capture this slot's bits when the write pointer lands on it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               slot_reg <= '0;
      else if (wr_en && (beat_cnt_reg == IDX)) slot_reg <= s_data[SW-1:0];
    end

    assign vec[LO +: SW] = slot_reg;
  end

  // Result capture and output beat sequencing; the first SEND cycle loads beat 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sh_reg  <= '0;
      out_cnt_reg <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else if (capture) begin
      res_sh_reg  <= RES_PW'(res);   // pad bits of the top beat read as 0
      out_cnt_reg <= '0;
    end else if (state_reg == S_SEND) begin
      if (!m_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= res_sh_reg[BEAT_W-1:0];
        m_last_reg  <= (out_cnt_reg == LAST_OUT);
      end else if (m_ready) begin
        if (m_last_reg) begin
          m_valid_reg <= 1'b0;
          m_last_reg  <= 1'b0;
          m_data_reg  <= '0;
          out_cnt_reg <= '0;
        end else begin
          res_sh_reg  <= res_shifted;
          m_data_reg  <= res_shifted[BEAT_W-1:0];
          out_cnt_reg <= out_cnt_inc;
          m_last_reg  <= (out_cnt_inc == LAST_OUT);
        end
      end
    end
  end

  // Sticky framing error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_frame_reg <= 1'b0;
    else if (set_err) err_frame_reg <= 1'b1;
  end

endmodule

// File: tb/tb_bdd_vector_loader.sv
// Testbench for bdd_vector_loader: directed frames, scoreboard of result beats.
module tb_bdd_vector_loader;

  localparam int IN_W   = 1894;
  localparam int OUT_W  = 96;
  localparam int BEAT_W = 32;
  localparam int NB_IN  = 60;
  localparam int NB_OUT = 3;
  localparam int PAD_W  = NB_IN * BEAT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  // main instance (EVAL_CYC=3), res driven by the bench
  logic [BEAT_W-1:0] s_data;
  logic              s_valid, s_last, s_ready;
  logic [IN_W-1:0]   vec;
  logic [OUT_W-1:0]  res_tb;
  logic [BEAT_W-1:0] m_data;
  logic              m_valid, m_last, m_ready, busy, err_frame;
  // second instance (EVAL_CYC=1), res looped back from vec
  logic [BEAT_W-1:0] s1_data;
  logic              s1_valid, s1_last, s1_ready;
  logic [IN_W-1:0]   vec1;
  logic [OUT_W-1:0]  res1;
  logic [BEAT_W-1:0] m1_data;
  logic              m1_valid, m1_last, m1_ready, busy1, err_frame1;

  assign res1 = vec1[OUT_W-1:0];

  bdd_vector_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .BEAT_W(BEAT_W), .EVAL_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .vec(vec), .res(res_tb),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err_frame(err_frame)
  );

  bdd_vector_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .BEAT_W(BEAT_W), .EVAL_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last), .s_ready(s1_ready),
    .vec(vec1), .res(res1),
    .m_data(m1_data), .m_valid(m1_valid), .m_last(m1_last), .m_ready(m1_ready),
    .busy(busy1), .err_frame(err_frame1)
  );

  typedef struct packed {
    logic [BEAT_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int total = 0;
  int bad   = 0;
  int xfer0 = 0;
  int xfer1 = 0;
  logic [PAD_W-1:0] exp_pad  = '0;
  logic [PAD_W-1:0] exp1_pad = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input bit sel, input string tag);
    logic [PAD_W-1:0] o;
    logic [PAD_W-1:0] e;
    int first;
    o = '0;
    o[IN_W-1:0] = sel ? vec1 : vec;
    e = sel ? exp1_pad : exp_pad;
    e[PAD_W-1:IN_W] = '0;
    total++;
    assert (o === e) else begin
      bad++;
      first = -1;
      for (int k = NB_IN - 1; k >= 0; k--)
        if (o[k*BEAT_W +: BEAT_W] !== e[k*BEAT_W +: BEAT_W]) first = k;
      $error("FAIL %s: slot %0d observed=%h expected=%h", tag, first,
             o[first*BEAT_W +: BEAT_W], e[first*BEAT_W +: BEAT_W]);
    end
  endtask

  // Output monitor for the main instance: scoreboard pop and stall stability
  bit stall0 = 0;
  logic [BEAT_W-1:0] stall_data0;
  always @(negedge clk) begin
    if (stall0 && rst_n) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, stall_data0);
    end
    stall0      = m_valid && !m_ready;
    stall_data0 = m_data;
    if (m_valid && m_ready) begin
      if (q0.size() == 0) begin
        check("unexpected_m_valid", m_valid, 0);
      end else begin
        beat_t e;
        e = q0.pop_front();
        check("m_data", m_data, e.d);
        check("m_last", m_last, e.l);
        xfer0++;
      end
    end
  end

  // Output monitor for the looped-back instance
  always @(negedge clk) begin
    if (m1_valid && m1_ready) begin
      if (q1.size() == 0) begin
        check("unexpected_m1_valid", m1_valid, 0);
      end else begin
        beat_t e;
        e = q1.pop_front();
        check("m1_data", m1_data, e.d);
        check("m1_last", m1_last, e.l);
        xfer1++;
      end
    end
  end

  task automatic drive_beat(input bit sel, input logic [BEAT_W-1:0] data, input bit last);
    int n;
    if (sel) begin s1_data = data; s1_last = last; s1_valid = 1'b1; end
    else     begin s_data  = data; s_last  = last; s_valid  = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? s1_ready : s_ready) && n < 200);
    if (n >= 200) check("s_ready_timeout", sel ? s1_ready : s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input int nbeats, input int last_at, input bit rnd);
    logic [BEAT_W-1:0] w;
    for (int k = 0; k < nbeats; k++) begin
      w = rnd ? BEAT_W'($urandom) : BEAT_W'(k);
      if (k < NB_IN) begin
        if (sel) exp1_pad[k*BEAT_W +: BEAT_W] = w;
        else     exp_pad[k*BEAT_W +: BEAT_W]  = w;
      end
      if (sel && k < NB_OUT) q1.push_back('{d: w, l: (k == NB_OUT - 1)});
      drive_beat(sel, w, k == last_at);
    end
    if (sel) begin s1_valid = 1'b0; s1_last = 1'b0; end
    else     begin s_valid  = 1'b0; s_last  = 1'b0; end
  endtask

  task automatic push_res0();
    res_tb = {$urandom, $urandom, $urandom};
    for (int j = 0; j < NB_OUT; j++)
      q0.push_back('{d: res_tb[j*BEAT_W +: BEAT_W], l: (j == NB_OUT - 1)});
  endtask

  task automatic wait_latency(input bit sel, input int expn);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sel ? m1_valid : m_valid) && n < 20);
    check(sel ? "valid_latency1" : "valid_latency", n, expn);
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while ((sel ? busy1 : busy) && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(sel ? "busy1_idle" : "busy_idle", sel ? busy1 : busy, 0);
  endtask

  task automatic legal_frame0(input bit rnd);
    int x0;
    x0 = xfer0;
    push_res0();
    send_frame(0, NB_IN, NB_IN - 1, rnd);
    check("s_ready_eval", s_ready, 0);
    check("busy_eval", busy, 1);
    wait_latency(0, 4);
    wait_idle(0);
    check("xfer_count", xfer0 - x0, NB_OUT);
    check("q0_empty", q0.size(), 0);
    check_vec(0, "vec");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    int n;
    rst_n = 1'b0;
    s_data = '0;  s_valid = 1'b0;  s_last = 1'b0;  m_ready = 1'b1;
    s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0; m1_ready = 1'b1;
    res_tb = '0;
    #12;
    // reset values
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_frame", err_frame, 0);
    check_vec(0, "rst_vec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // legal frame, s_data = beat index
    legal_frame0(0);
    check("err_after_legal", err_frame, 0);

    // backpressure: stall 10 cycles then toggle m_ready
    m_ready = 1'b0;
    x0 = xfer0;
    push_res0();
    send_frame(0, NB_IN, NB_IN - 1, 1);
    wait_latency(0, 4);
    repeat (10) begin @(posedge clk); #1; end
    check("stall_no_xfer", xfer0 - x0, 0);
    n = 0;
    while (busy && n < 40) begin
      m_ready = ~m_ready;
      @(posedge clk); #1;
      n++;
    end
    check("bp_busy", busy, 0);
    check("bp_xfer_count", xfer0 - x0, NB_OUT);
    check("bp_m_valid", m_valid, 0);
    m_ready = 1'b1;
    check_vec(0, "bp_vec");

    // early s_last on beat 20
    x0 = xfer0;
    send_frame(0, 21, 20, 1);
    repeat (8) begin @(posedge clk); #1; end
    check("early_err", err_frame, 1);
    check("early_busy", busy, 0);
    check("early_no_xfer", xfer0 - x0, 0);
    check_vec(0, "early_vec");
    legal_frame0(1);
    check("err_sticky", err_frame, 1);

    // missing s_last on beat 59, drained through beat 64
    x0 = xfer0;
    send_frame(0, 65, 64, 1);
    check("drain_busy", busy, 0);
    repeat (8) begin @(posedge clk); #1; end
    check("drain_no_xfer", xfer0 - x0, 0);
    check_vec(0, "drain_vec");
    legal_frame0(1);

    // reset mid-LOAD after beat 30
    send_frame(0, 31, -1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_pad = '0;
    check("rl_s_ready", s_ready, 0);
    check("rl_busy", busy, 0);
    check("rl_err_frame", err_frame, 0);
    check("rl_m_valid", m_valid, 0);
    check_vec(0, "rl_vec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    legal_frame0(1);

    // reset mid-SEND while beat 1 is presented
    x0 = xfer0;
    push_res0();
    send_frame(0, NB_IN, NB_IN - 1, 1);
    n = 0;
    while (xfer0 == x0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("rs_beat0_done", xfer0 - x0, 1);
    check("rs_beat1_valid", m_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    q0.delete();
    exp_pad = '0;
    check("rs_m_valid", m_valid, 0);
    check("rs_m_last", m_last, 0);
    check("rs_m_data", m_data, 0);
    check("rs_busy", busy, 0);
    check("rs_s_ready", s_ready, 0);
    check_vec(0, "rs_vec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    legal_frame0(1);

    // EVAL_CYC=1 instance with res looped back from vec[95:0]
    x0 = xfer1;
    send_frame(1, NB_IN, NB_IN - 1, 1);
    wait_latency(1, 2);
    wait_idle(1);
    check("lb_xfer_count", xfer1 - x0, NB_OUT);
    check("lb_q1_empty", q1.size(), 0);
    check("lb_err_frame", err_frame1, 0);
    check_vec(1, "lb_vec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
